// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense/argmax parameter streamer.
package dense_pkg;

  // Q1.15 word width
  localparam int unsigned Q_W = 16;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StFetchW,
    StFetchB,
    StPresent
  } dstream_state_t;

  // Batch count for the default geometry (N = 100, SETS = 10)
  localparam int unsigned DEF_N    = 100;
  localparam int unsigned DEF_SETS = 10;
  localparam int unsigned BATCHES  = ceil_div(DEF_N, DEF_SETS);

endpackage

// File: rtl/dstream_addr_gen.sv
// Combinational address/pad/last-word decode for one fetch phase of the streamer.
module dstream_addr_gen #(
  parameter int unsigned M      = 10,
  parameter int unsigned N      = 100,
  parameter int unsigned SETS   = 10,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WBASE  = 0,
  parameter int unsigned BBASE  = M * N,
  parameter int unsigned KW     = 7
) (
  input  logic [7:0]        b_i,
  input  logic [KW-1:0]     k_i,
  input  logic              phase_i,  // 0: weights, 1: biases
  output logic [ADDR_W-1:0] addr_o,
  output logic              pad_o,
  output logic              last_o
);

  localparam int unsigned Sm = SETS * M;

  logic [31:0]       row;
  logic [ADDR_W-1:0] base;

  // Row of word k in batch b decides padding; address math is kept at ADDR_W bits.
  always_comb begin
    row    = 32'(b_i) * SETS + 32'(k_i) / M;
    base   = phase_i ? ADDR_W'(BBASE) : ADDR_W'(WBASE);
    addr_o = base + ADDR_W'(32'(b_i) * Sm) + ADDR_W'(k_i);
    pad_o  = (row >= N);
    last_o = (k_i == KW'(Sm));
  end

endmodule

// File: rtl/dense_param_streamer.sv
// Parameter streamer: fetches weight (and optionally bias) batches from a synchronous
// single-port memory and presents them over a valid/ready handshake.
// Build option: define DSTREAM_BIAS_FETCH_EN to fetch biases; otherwise biases read as 0.
module dense_param_streamer
  import dense_pkg::*;
#(
  parameter int unsigned M      = 10,
  parameter int unsigned N      = 100,
  parameter int unsigned SETS   = 10,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WBASE  = 0,
  parameter int unsigned BBASE  = M * N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   mem_rd_en_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic [Q_W-1:0]         mem_rdata_i,
  output logic [Q_W*SETS*M-1:0]  batch_weights_o,
  output logic [Q_W*SETS*M-1:0]  batch_biases_o,
  output logic [7:0]             batch_idx_o,
  output logic                   batch_last_o,
  output logic                   batch_valid_o,
  input  logic                   batch_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned Sm      = SETS * M;
  localparam int unsigned KW      = $clog2(Sm + 1);
  localparam int unsigned IW      = (Sm > 1) ? $clog2(Sm) : 1;
  localparam int unsigned Batches = ceil_div(N, SETS);
  localparam logic [7:0]  LastB   = 8'(Batches - 1);

  dstream_state_t state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [7:0]     b_q, b_d;
  logic           done_q, done_d;

  // Capture pipeline: describes the word whose read data arrives this cycle
  logic           cap_vld_q;
  logic           cap_pad_q;
  logic [IW-1:0]  cap_idx_q;
`ifdef DSTREAM_BIAS_FETCH_EN
  logic           cap_bias_q;
`endif

  logic [Q_W-1:0] wbuf_q [Sm];
`ifdef DSTREAM_BIAS_FETCH_EN
  logic [Q_W-1:0] bbuf_q [Sm];
`endif

  logic              phase;
  logic              issue;
  logic              pad;
  logic              last_word;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;

  assign phase = (state_q == StFetchB);

  dstream_addr_gen #(
    .M      (M),
    .N      (N),
    .SETS   (SETS),
    .ADDR_W (ADDR_W),
    .WBASE  (WBASE),
    .BBASE  (BBASE),
    .KW     (KW)
  ) u_addr_gen (
    .b_i     (b_q),
    .k_i     (k_q),
    .phase_i (phase),
    .addr_o  (addr),
    .pad_o   (pad),
    .last_o  (last_word)
  );

  // Next-state, counters and handshake decode.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    b_d           = b_q;
    done_d        = 1'b0;
    issue         = 1'b0;
    rd_en         = 1'b0;
    batch_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          b_d     = '0;
          k_d     = '0;
          state_d = StFetchW;
        end
      end
      StFetchW: begin
        issue = !last_word;
        rd_en = !last_word && !pad;
        if (last_word) begin
          k_d = '0;
`ifdef DSTREAM_BIAS_FETCH_EN
          state_d = StFetchB;
`else
          state_d = StPresent;
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
`ifdef DSTREAM_BIAS_FETCH_EN
      StFetchB: begin
        issue = !last_word;
        rd_en = !last_word && !pad;
        if (last_word) begin
          k_d     = '0;
          state_d = StPresent;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
`endif
      StPresent: begin
        batch_valid_o = 1'b1;
        if (batch_ready_i) begin
          if (b_q == LastB) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            b_d     = b_q + 8'd1;
            k_d     = '0;
            state_d = StFetchW;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and capture pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      b_q        <= '0;
      done_q     <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_pad_q  <= 1'b0;
      cap_idx_q  <= '0;
`ifdef DSTREAM_BIAS_FETCH_EN
      cap_bias_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      b_q        <= b_d;
      done_q     <= done_d;
      cap_vld_q  <= issue;
      cap_pad_q  <= pad;
      cap_idx_q  <= IW'(k_q);
`ifdef DSTREAM_BIAS_FETCH_EN
      cap_bias_q <= phase;
`endif
    end
  end

  // Word buffers: pad words are written as 0 so stale data never leaks into a batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Sm; i++) begin
        wbuf_q[i] <= '0;
`ifdef DSTREAM_BIAS_FETCH_EN
        bbuf_q[i] <= '0;
`endif
      end
    end else if (cap_vld_q) begin
`ifdef DSTREAM_BIAS_FETCH_EN
      if (cap_bias_q) begin
        bbuf_q[cap_idx_q] <= cap_pad_q ? '0 : mem_rdata_i;
      end else begin
        wbuf_q[cap_idx_q] <= cap_pad_q ? '0 : mem_rdata_i;
      end
`else
      wbuf_q[cap_idx_q] <= cap_pad_q ? '0 : mem_rdata_i;
`endif
    end
  end

  // Output packing: word i sits at bits [i*Q_W +: Q_W].
  always_comb begin
    batch_weights_o = '0;
    batch_biases_o  = '0;
    for (int i = 0; i < Sm; i++) begin
      batch_weights_o[i*Q_W +: Q_W] = wbuf_q[i];
`ifdef DSTREAM_BIAS_FETCH_EN
      batch_biases_o[i*Q_W +: Q_W]  = bbuf_q[i];
`endif
    end
  end

  assign mem_rd_en_o  = rd_en;
  assign mem_addr_o   = rd_en ? addr : '0;
  assign batch_idx_o  = b_q;
  assign batch_last_o = (state_q == StPresent) && (b_q == LastB);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;

endmodule

// File: tb/tb_dense_param_streamer.sv
// Bench for dense_param_streamer: two instances (N=4 and N=3, M=2, SETS=2) share stimulus;
// memory returns word = address. Expectations follow DSTREAM_BIAS_FETCH_EN.
module tb_dense_param_streamer;

  localparam int M    = 2;
  localparam int SETS = 2;
  localparam int SM   = 4;
  localparam int NB   = 2;
`ifdef DSTREAM_BIAS_FETCH_EN
  localparam bit BiasEn = 1'b1;
  localparam int Lat    = 10;
`else
  localparam bit BiasEn = 1'b0;
  localparam int Lat    = 5;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic        rd_en [2];
  logic [15:0] addr  [2];
  logic [15:0] rdata [2];
  logic [63:0] wts   [2];
  logic [63:0] bis   [2];
  logic [7:0]  idx   [2];
  logic        last  [2];
  logic        valid [2];
  logic        busy  [2];
  logic        done  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dense_param_streamer #(.M(2), .N(4), .SETS(2), .ADDR_W(16), .WBASE(0)) dut0 (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .mem_rd_en_o     (rd_en[0]),
    .mem_addr_o      (addr[0]),
    .mem_rdata_i     (rdata[0]),
    .batch_weights_o (wts[0]),
    .batch_biases_o  (bis[0]),
    .batch_idx_o     (idx[0]),
    .batch_last_o    (last[0]),
    .batch_valid_o   (valid[0]),
    .batch_ready_i   (ready),
    .busy_o          (busy[0]),
    .done_o          (done[0])
  );

  dense_param_streamer #(.M(2), .N(3), .SETS(2), .ADDR_W(16), .WBASE(0), .BBASE(8)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .mem_rd_en_o     (rd_en[1]),
    .mem_addr_o      (addr[1]),
    .mem_rdata_i     (rdata[1]),
    .batch_weights_o (wts[1]),
    .batch_biases_o  (bis[1]),
    .batch_idx_o     (idx[1]),
    .batch_last_o    (last[1]),
    .batch_valid_o   (valid[1]),
    .batch_ready_i   (ready),
    .busy_o          (busy[1]),
    .done_o          (done[1])
  );

  // Synchronous memories: word = address; junk when not read so pad zeros are visible.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) rdata[i] <= rd_en[i] ? addr[i] : 16'hdead;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_word(int inst, int b, int k, bit bias);
    int n  = (inst == 0) ? 4 : 3;
    int bb = 8;
    int r  = b * SETS + k / M;
    if (r >= n || (bias && !BiasEn)) return 16'h0;
    return 16'((bias ? bb : 0) + b * SM + k);
  endfunction

  function automatic logic [63:0] exp_vec(int inst, int b, bit bias);
    logic [63:0] v = '0;
    for (int k = 0; k < SM; k++) v[k*16 +: 16] = exp_word(inst, b, k, bias);
    return v;
  endfunction

  function automatic bit rd_legal(int inst, logic [15:0] a);
    int n = (inst == 0) ? 4 : 3;
    if (int'(a) < n * M) return 1'b1;
    if (BiasEn && int'(a) >= 8 && int'(a) < 8 + n * M) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction-level model: when each batch should appear, which batch, when done pulses.
  int cyc        = 0;
  bit m_active   = 1'b0;
  int m_b        = 0;
  int m_vcyc     = 0;
  int m_done_cyc = -100;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active   = 1'b0;
      m_b        = 0;
      m_done_cyc = -100;
    end else begin
      cyc++;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_b      = 0;
          m_vcyc   = cyc + Lat;
        end
      end else if (cyc - 1 >= m_vcyc && ready) begin
        if (m_b == NB - 1) begin
          m_active   = 1'b0;
          m_done_cyc = cyc;
        end else begin
          m_b++;
          m_vcyc = cyc + Lat;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit ev;
    ev = m_active && (cyc >= m_vcyc);
    for (int i = 0; i < 2; i++) begin
      chk("valid", 64'(valid[i]), 64'(ev));
      chk("busy", 64'(busy[i]), 64'(m_active));
      chk("done", 64'(done[i]), 64'(cyc == m_done_cyc));
      if (ev) begin
        chk("weights", wts[i], exp_vec(i, m_b, 1'b0));
        chk("biases", bis[i], exp_vec(i, m_b, 1'b1));
        chk("idx", 64'(idx[i]), 64'(m_b));
        chk("last", 64'(last[i]), 64'(m_b == NB - 1));
      end
      if (rd_en[i]) chk("rd_legal", 64'(rd_legal(i, addr[i]) && !ev), 64'd1);
    end
  end

  task automatic pulse_start(output int se);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 se = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!valid[0]) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got timeout expected batch_valid within 400 cycles");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy[0]) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy expected idle within 400 cycles");
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_valid"}, 64'(valid[i]), 64'd0);
      chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
      chk({tag, "_rd_en"}, 64'(rd_en[i]), 64'd0);
      chk({tag, "_done"}, 64'(done[i]), 64'd0);
      chk({tag, "_weights"}, wts[i], 64'd0);
      chk({tag, "_biases"}, bis[i], 64'd0);
      chk({tag, "_idx"}, 64'(idx[i]), 64'd0);
      chk({tag, "_last"}, 64'(last[i]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int se;
    int te;
    int nxfer;
    logic [63:0] snap;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    check_zero("reset");

    // Basic batch 0 with backpressure, start pulsed while busy
    pulse_start(se);
    wait_valid();
    chk("lat_b0", 64'(cyc - se), 64'(Lat));
    chk("b0_weights_lit", wts[0], 64'h0003_0002_0001_0000);
    chk("b0_biases_lit", bis[0], BiasEn ? 64'h000b_000a_0009_0008 : 64'h0);
    chk("b0_last_lit", 64'(last[0]), 64'd0);
    snap = wts[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("hold_weights", wts[0], snap);
    end
    ready = 1'b1;
    @(negedge clk);
    te = cyc;
    ready = 1'b0;
    wait_valid();
    chk("lat_b1", 64'(cyc - te), 64'(Lat));
    chk("b1_weights_lit", wts[0], 64'h0007_0006_0005_0004);
    chk("b1_idx_lit", 64'(idx[0]), 64'd1);
    chk("b1_last_lit", 64'(last[0]), 64'd1);
    chk("pad_weights_lit", wts[1], 64'h0000_0000_0005_0004);
    chk("pad_biases_lit", bis[1], BiasEn ? 64'h0000_0000_000d_000c : 64'h0);
    ready = 1'b1;
    @(negedge clk);
    chk("done_pulse_lit", 64'(done[0]), 64'd1);
    ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle_lit", 64'(done[0]), 64'd0);
    chk("idle_after_done_lit", 64'(busy[0]), 64'd0);

    // Back-to-back batches with ready held high
    ready = 1'b1;
    pulse_start(se);
    nxfer = 0;
    for (int n = 0; n < 4 * Lat + 10 && (busy[0] || nxfer == 0); n++) begin
      @(negedge clk);
      if (valid[0]) nxfer++;
    end
    chk("b2b_transfers", 64'(nxfer), 64'd2);
    ready = 1'b0;
    wait_idle();

    // Reset during batch-1 fetch, then full re-run
    pulse_start(se);
    wait_valid();
    ready = 1'b1;
    @(negedge clk);
    te = cyc;
    ready = 1'b0;
    while (cyc < te + (BiasEn ? 7 : 3)) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    pulse_start(se);
    wait_valid();
    chk("rerun_lat", 64'(cyc - se), 64'(Lat));
    chk("rerun_weights_lit", wts[0], 64'h0003_0002_0001_0000);
    chk("rerun_idx_lit", 64'(idx[0]), 64'd0);
    ready = 1'b1;
    wait_idle();
    ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
